router_fsm_nch: RTL

Parametrised successor to the 3-channel router controller FSM. It sequences one input packet stream (header, payload, parity) into one of NCH destination FIFOs. Compared with the fixed 3-channel version it adds:
- per-destination empty/soft-reset checks, using only the addressed channel;
- a latched destination index output;
- invalid-address packet discard;
- a bounded wait-for-empty with timeout and drop.

It sits between the input register/parity block and the FIFO-select/synchroniser block.

---
 rtl/router_fsm_nch_pkg.sv | 20 ++
 rtl/router_fsm_nch_wait_timer.sv | 29 ++
 rtl/router_fsm_nch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/router_fsm_nch_pkg.sv
// Shared definitions for the packet router: state encoding and default channel geometry.
package router_fsm_nch_pkg;

    localparam int DEF_NCH = 3;
    localparam int DEF_AW  = 2;
    localparam int DEF_DW  = 8;

    typedef enum logic [3:0] {
        DECODE       = 4'd0,
        LOAD_FIRST   = 4'd1,
        WAIT_EMPTY   = 4'd2,
        LOAD_DATA    = 4'd3,
        LOAD_PARITY  = 4'd4,
        CHECK_PARITY = 4'd5,
        FIFO_FULL    = 4'd6,
        LOAD_AFTER   = 4'd7,
        DROP         = 4'd8
    } state_t;

endpackage

// File: rtl/router_fsm_nch_wait_timer.sv
// Saturating wait counter; expire flags the last allowed cycle (never when WAIT_MAX is 0).
module router_wait_timer #(
    parameter int CW       = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CW-1:0] LAST = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

    logic [CW-1:0] cnt;

    assign expire = (WAIT_MAX != 0) && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/router_fsm_nch.sv
// Packet router controller: steers header/payload/parity of one stream into one of NCH FIFOs,
// discarding packets with bad addresses or whose destination never drains.
module router_fsm_nch
    import router_fsm_nch_pkg::*;
#(
    parameter int NCH      = DEF_NCH,
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int WAIT_MAX = 255,
    parameter int CW       = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pktvalid,
    input  logic [DW-1:0]  data,
    input  logic           fifofull,
    input  logic [NCH-1:0] fifoempty,
    input  logic [NCH-1:0] softreset,
    input  logic           lowpktvalid,
    input  logic           paritydone,
    output logic [AW-1:0]  destaddr,
    output logic           detectadd,
    output logic           lfdstate,
    output logic           ldstate,
    output logic           fullstate,
    output logic           lafstate,
    output logic           rstintreg,
    output logic           writeenreg,
    output logic           busy,
    output logic           pktdrop
);

    localparam int NSLOT = 2 ** AW;

    state_t           state;
    logic [NSLOT-1:0] empty_ext;
    logic [NSLOT-1:0] sreset_ext;
    logic [AW-1:0]    hdr_addr;
    logic             hdr_bad;
    logic             sel_sreset;
    logic             wait_clr;
    logic             wait_en;
    logic             wait_expire;
    logic             unused_data;

    // Widen the per-channel flags so any AW-bit index is in range.
    assign empty_ext   = NSLOT'(fifoempty);
    assign sreset_ext  = NSLOT'(softreset);
    assign hdr_addr    = data[AW-1:0];
    assign hdr_bad     = 32'(hdr_addr) >= NCH;
    assign unused_data = ^data;

    assign sel_sreset = sreset_ext[destaddr] && (state != DECODE) && (state != DROP);
    assign wait_clr   = (state == DECODE);
    assign wait_en    = (state == WAIT_EMPTY) && !empty_ext[destaddr] && !wait_expire;

    router_wait_timer #(
        .CW       (CW),
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .en     (wait_en),
        .expire (wait_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= DECODE;
            destaddr <= '0;
            pktdrop  <= 1'b0;
        end else begin
            pktdrop <= (state == DROP) && !pktvalid;
            if (sel_sreset) begin
                state <= DECODE;
            end else begin
                case (state)
                    DECODE: begin
                        if (pktvalid) begin
                            destaddr <= hdr_addr;
                            if (hdr_bad)                  state <= DROP;
                            else if (empty_ext[hdr_addr]) state <= LOAD_FIRST;
                            else                          state <= WAIT_EMPTY;
                        end
                    end
                    LOAD_FIRST: state <= LOAD_DATA;
                    WAIT_EMPTY: begin
                        if (empty_ext[destaddr]) state <= LOAD_FIRST;
                        else if (wait_expire)    state <= DROP;
                    end
                    LOAD_DATA: begin
                        if (fifofull)       state <= FIFO_FULL;
                        else if (!pktvalid) state <= LOAD_PARITY;
                    end
                    LOAD_PARITY:  state <= CHECK_PARITY;
                    CHECK_PARITY: state <= fifofull ? FIFO_FULL : DECODE;
                    FIFO_FULL: begin
                        if (!fifofull) state <= LOAD_AFTER;
                    end
                    LOAD_AFTER: begin
                        if (paritydone)       state <= DECODE;
                        else if (lowpktvalid) state <= LOAD_PARITY;
                        else                  state <= LOAD_DATA;
                    end
                    DROP: begin
                        if (!pktvalid) state <= DECODE;
                    end
                    default: state <= DECODE;
                endcase
            end
        end
    end

    assign detectadd  = (state == DECODE);
    assign lfdstate   = (state == LOAD_FIRST);
    assign ldstate    = (state == LOAD_DATA);
    assign fullstate  = (state == FIFO_FULL);
    assign lafstate   = (state == LOAD_AFTER);
    assign rstintreg  = (state == CHECK_PARITY);
    assign writeenreg = (state == LOAD_DATA) || (state == LOAD_PARITY) || (state == LOAD_AFTER);
    assign busy       = (state != DECODE) && (state != LOAD_DATA);

endmodule
